// File: rtl/uart_rx_cfg.sv
// 8N1 UART receiver with a runtime baud divisor (bit period = DB+1 clocks), LSB first.
// Define UART_RX_FRM_ERR_EN to report stop-bit framing errors on frm_err; otherwise frm_err is tied low.
module uart_rx_cfg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic [12:0] DB,
    input  logic        clr_rdy,
    output logic [7:0]  rx_data,
    output logic        rdy,
    output logic        frm_err
);

    typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        rx_meta_q, rx_s_q;
    logic [12:0] baud_cnt_q, baud_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [8:0]  shft_q, shft_d;
    logic        rdy_q, rdy_d;
    logic        sample, start_det, stop_sample;

    // Two-flop synchronizer; presets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (!rx_s_q) state_d = RECV;
            RECV: begin
                if (sample) begin
                    if (bit_cnt_q == 4'd0 && rx_s_q) state_d = IDLE;
                    else if (bit_cnt_q == 4'd9)      state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_det   = (state_q == IDLE) && !rx_s_q;
        sample      = (state_q == RECV) && (baud_cnt_q == 13'd0);
        stop_sample = sample && (bit_cnt_q == 4'd9);
    end

    // First sample lands mid start bit (half period), then one full period per bit.
    always_comb begin
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shft_d     = shft_q;
        rdy_d      = rdy_q;
        if (start_det) begin
            baud_cnt_d = {1'b0, DB[12:1]};
            bit_cnt_d  = 4'd0;
        end else if (sample) begin
            baud_cnt_d = DB;
            bit_cnt_d  = bit_cnt_q + 4'd1;
            shft_d     = {rx_s_q, shft_q[8:1]};
        end else if (state_q == RECV) begin
            baud_cnt_d = baud_cnt_q - 13'd1;
        end
        if (stop_sample)                rdy_d = 1'b1;
        else if (clr_rdy || start_det)  rdy_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_q <= 13'd0;
            bit_cnt_q  <= 4'd0;
            shft_q     <= 9'h1FF;
            rdy_q      <= 1'b0;
        end else begin
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shft_q     <= shft_d;
            rdy_q      <= rdy_d;
        end
    end

`ifdef UART_RX_FRM_ERR_EN
    logic frm_err_q, frm_err_d;

    always_comb begin
        frm_err_d = frm_err_q;
        if (stop_sample)               frm_err_d = ~rx_s_q;
        else if (clr_rdy || start_det) frm_err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frm_err_q <= 1'b0;
        else        frm_err_q <= frm_err_d;
    end

    assign frm_err = frm_err_q;
`else
    assign frm_err = 1'b0;
`endif

    assign rx_data = shft_q[7:0];
    assign rdy     = rdy_q;

endmodule
